peripheral_timer_bus: RTL and testbench

- Memory-mapped peripheral block downstream of the CPU data path.
- Consumes the peripheral write strobe, ALU address and DataBusB write data for addresses with bit 30 set.
- Returns read data for the MemtoReg mux and drives the IRQ input of the control unit.
- Contains a reloadable 32-bit timer with an interrupt, LED and digit-tube output registers, a synchronised switch input, and a free-running system tick counter.

---
 rtl/peripheral_timer_bus_pkg.sv | 26 ++
 rtl/peripheral_timer_bus_timer.sv | 61 ++++++
 rtl/peripheral_timer_bus.sv | 103 ++++++++++
 tb/tb_peripheral_timer_bus.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_timer_bus_pkg.sv
// rtl/peripheral_timer_bus_pkg.sv - shared constants for the peripheral timer bus block
package peripheral_timer_bus_pkg;

    // Byte offsets of the registers from the window base.
    localparam logic [31:0] OFS_TH      = 32'h00;
    localparam logic [31:0] OFS_TL      = 32'h04;
    localparam logic [31:0] OFS_TCON    = 32'h08;
    localparam logic [31:0] OFS_LED     = 32'h0C;
    localparam logic [31:0] OFS_SWITCH  = 32'h10;
    localparam logic [31:0] OFS_DIGI    = 32'h14;
    localparam logic [31:0] OFS_SYSTICK = 32'h18;

    // TCON bit positions.
    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    // Register widths.
    localparam int TIMER_W = 32;
    localparam int TCON_W  = 3;
    localparam int LED_W   = 8;
    localparam int SW_W    = 8;
    localparam int DIGI_W  = 12;
    localparam int TICK_W  = 32;

endpackage

// File: rtl/peripheral_timer_bus_timer.sv
// rtl/peripheral_timer_bus_timer.sv - reloadable 32-bit timer with interrupt status
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   wr_th, wr_tl, wr_tcon decoded write strobes
//   wdata                write data
//   th, tl, tcon         current register state
//   irqout               interrupt request (irq_en & irq_status)
module periph_timer
    import peripheral_timer_bus_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_th,
    input  logic               wr_tl,
    input  logic               wr_tcon,
    input  logic [31:0]        wdata,
    output logic [TIMER_W-1:0] th,
    output logic [TIMER_W-1:0] tl,
    output logic [TCON_W-1:0]  tcon,
    output logic               irqout
);

    logic overflow;
    logic set_status;

    assign overflow   = tcon[TCON_EN] && (tl == {TIMER_W{1'b1}});
    assign set_status = overflow && tcon[TCON_IE];

    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr_th) begin
                th <= wdata;
            end

            // A CPU write to TL beats both increment and reload.
            if (wr_tl) begin
                tl <= wdata;
            end else if (tcon[TCON_EN]) begin
                tl <= overflow ? th : tl + 1'b1;
            end

            if (wr_tcon) begin
                tcon[TCON_EN] <= wdata[TCON_EN];
                tcon[TCON_IE] <= wdata[TCON_IE];
                // An overflow in the same cycle keeps the status set so no
                // interrupt is lost to a racing software clear.
                tcon[TCON_ST] <= wdata[TCON_ST] | set_status;
            end else if (set_status) begin
                tcon[TCON_ST] <= 1'b1;
            end
        end
    end

    assign irqout = tcon[TCON_IE] & tcon[TCON_ST];

endmodule

// File: rtl/peripheral_timer_bus.sv
// rtl/peripheral_timer_bus.sv - memory-mapped timer, LED, digit-tube, switch and systick block
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   rd, wr       peripheral read / write enables
//   addr, wdata  byte address and write data
//   rdata        combinational read data (0 when rd=0 or unmapped)
//   switch_in    asynchronous board switches
//   led, digi    output registers
//   irqout       timer interrupt request
module peripheral_timer_bus
    import peripheral_timer_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h40000000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [SW_W-1:0]   switch_in,
    output logic [LED_W-1:0]  led,
    output logic [DIGI_W-1:0] digi,
    output logic              irqout
);

    // Word address: the two byte-select bits drop out of the compare.
    logic [31:0] word_addr;
    assign word_addr = addr >> 2;

    function automatic logic hit(input logic [31:0] word, input logic [31:0] ofs);
        return word == ((BASE_ADDR >> 2) + (ofs >> 2));
    endfunction

    logic hit_th, hit_tl, hit_tcon, hit_led, hit_switch, hit_digi, hit_systick;
    assign hit_th      = hit(word_addr, OFS_TH);
    assign hit_tl      = hit(word_addr, OFS_TL);
    assign hit_tcon    = hit(word_addr, OFS_TCON);
    assign hit_led     = hit(word_addr, OFS_LED);
    assign hit_switch  = hit(word_addr, OFS_SWITCH);
    assign hit_digi    = hit(word_addr, OFS_DIGI);
    assign hit_systick = hit(word_addr, OFS_SYSTICK);

    logic [TIMER_W-1:0] th;
    logic [TIMER_W-1:0] tl;
    logic [TCON_W-1:0]  tcon;

    periph_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (wr && hit_th),
        .wr_tl   (wr && hit_tl),
        .wr_tcon (wr && hit_tcon),
        .wdata   (wdata),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irqout  (irqout)
    );

    logic [TICK_W-1:0] systick;
    logic [SW_W-1:0]   sync_q [SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            led     <= '0;
            digi    <= '0;
            systick <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            if (wr && hit_led) begin
                led <= wdata[LED_W-1:0];
            end
            if (wr && hit_digi) begin
                digi <= wdata[DIGI_W-1:0];
            end
            systick   <= systick + 1'b1;
            sync_q[0] <= switch_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (hit_th)           rdata = th;
            else if (hit_tl)      rdata = tl;
            else if (hit_tcon)    rdata = {{(32-TCON_W){1'b0}}, tcon};
            else if (hit_led)     rdata = {{(32-LED_W){1'b0}}, led};
            else if (hit_switch)  rdata = {{(32-SW_W){1'b0}}, sync_q[SYNC_STAGES-1]};
            else if (hit_digi)    rdata = {{(32-DIGI_W){1'b0}}, digi};
            else if (hit_systick) rdata = systick;
        end
    end

endmodule

// File: tb/tb_peripheral_timer_bus.sv
// tb/tb_peripheral_timer_bus.sv - directed self-checking bench for peripheral_timer_bus
module tb_peripheral_timer_bus;

    localparam int SYNC_STAGES = 2;
    localparam logic [31:0] B = 32'h40000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  switch_in;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irqout;

    int total = 0;
    int bad   = 0;

    peripheral_timer_bus #(
        .BASE_ADDR   (B),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .switch_in (switch_in),
        .led       (led),
        .digi      (digi),
        .irqout    (irqout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Drives one write cycle; returns 1 ns after the capturing edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1;
        addr = a;
        wdata = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        rd = 1'b1;
        addr = a;
        #1;
        d = rdata;
        rd = 1'b0;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] v;
    logic [31:0] t0;
    logic [31:0] t1;

    initial begin
        reset = 1'b1;
        rd = 1'b0;
        wr = 1'b0;
        addr = '0;
        wdata = '0;
        switch_in = 8'h00;
        tick();
        tick();

        // Reset state, sampled while reset still holds systick at 0.
        for (int k = 0; k < 7; k++) begin
            bus_read(B + 32'(k * 4), v);
            chk($sformatf("reset_rd_%0d", k), v, 32'h0);
        end
        chk("reset_irq", {31'b0, irqout}, 32'h0);
        reset = 1'b0;

        // Rollover and interrupt.
        bus_write(B + 32'h00, 32'hFFFFFFFC);
        bus_write(B + 32'h04, 32'hFFFFFFFE);
        bus_write(B + 32'h08, 32'h3);
        bus_read(B + 32'h04, v);
        chk("tl_start", v, 32'hFFFFFFFE);
        tick();
        bus_read(B + 32'h04, v);
        chk("tl_ffff", v, 32'hFFFFFFFF);
        chk("irq_before", {31'b0, irqout}, 32'h0);
        tick();
        bus_read(B + 32'h04, v);
        chk("tl_reload", v, 32'hFFFFFFFC);
        chk("irq_rise", {31'b0, irqout}, 32'h1);
        bus_read(B + 32'h08, v);
        chk("tcon_st", v, 32'h7);
        bus_write(B + 32'h08, 32'h3);
        chk("irq_clear", {31'b0, irqout}, 32'h0);

        // Overflow coincident with a clearing TCON write: the set wins.
        bus_write(B + 32'h04, 32'hFFFFFFFF);
        bus_write(B + 32'h08, 32'h3);
        bus_read(B + 32'h08, v);
        chk("race_tcon", v, 32'h7);
        chk("race_irq", {31'b0, irqout}, 32'h1);
        bus_write(B + 32'h08, 32'h3);
        chk("race_clear", {31'b0, irqout}, 32'h0);

        // CPU write to TL overrides increment.
        bus_write(B + 32'h04, 32'd5);
        bus_write(B + 32'h04, 32'd100);
        bus_read(B + 32'h04, v);
        chk("tl_wr_100", v, 32'd100);
        tick();
        bus_read(B + 32'h04, v);
        chk("tl_wr_101", v, 32'd101);
        bus_write(B + 32'h08, 32'h0);

        // LED / DIGI.
        bus_write(B + 32'h0C, 32'hFFFFFFA5);
        bus_write(B + 32'h14, 32'hFFFFF3C7);
        bus_read(B + 32'h0C, v);
        chk("led_rd", v, 32'hA5);
        bus_read(B + 32'h14, v);
        chk("digi_rd", v, 32'h3C7);
        chk("led_port", {24'b0, led}, 32'hA5);
        chk("digi_port", {20'b0, digi}, 32'h3C7);
        // Byte-select bits are ignored by decode.
        bus_read(B + 32'h0F, v);
        chk("led_rd_lsb", v, 32'hA5);

        // Read during a write returns the pre-write value.
        rd = 1'b1;
        wr = 1'b1;
        addr = B + 32'h0C;
        wdata = 32'h11;
        #1;
        chk("rdwr_old", rdata, 32'hA5);
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
        bus_read(B + 32'h0C, v);
        chk("rdwr_new", v, 32'h11);

        // Writes to RO and unmapped addresses.
        bus_write(B + 32'h10, 32'hFF);
        bus_write(B + 32'h20, 32'hFFFFFFFF);
        bus_read(B + 32'h10, v);
        chk("switch_ro", v, 32'h0);
        bus_read(B + 32'h20, v);
        chk("unmapped_rd", v, 32'h0);
        bus_read(B + 32'h0C, v);
        chk("led_kept", v, 32'h11);
        bus_read(B + 32'h00, v);
        chk("th_kept", v, 32'hFFFFFFFC);

        // Switch synchroniser latency.
        switch_in = 8'h5A;
        for (int i = 1; i <= SYNC_STAGES; i++) begin
            tick();
            bus_read(B + 32'h10, v);
            chk($sformatf("switch_c%0d", i), v, (i == SYNC_STAGES) ? 32'h5A : 32'h0);
        end

        // SYSTICK difference.
        bus_read(B + 32'h18, t0);
        repeat (7) @(posedge clk);
        #1;
        bus_read(B + 32'h18, t1);
        chk("systick_diff", t1 - t0, 32'd7);

        // TH all ones: overflow every cycle; then reset mid-count.
        bus_write(B + 32'h00, 32'hFFFFFFFF);
        bus_write(B + 32'h04, 32'hFFFFFFFF);
        bus_write(B + 32'h08, 32'h3);
        tick();
        chk("ovf_irq", {31'b0, irqout}, 32'h1);
        bus_read(B + 32'h04, v);
        chk("ovf_tl", v, 32'hFFFFFFFF);
        reset = 1'b1;
        tick();
        chk("rst_irq", {31'b0, irqout}, 32'h0);
        bus_read(B + 32'h04, v);
        chk("rst_tl", v, 32'h0);
        bus_read(B + 32'h08, v);
        chk("rst_tcon", v, 32'h0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
